dmem_responder: RTL and testbench

//  Memory-side responder for core load/store traffic. Single-port word RAM behind a valid/ready

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word RAM behind a valid/ready request channel
// and a valid/ready response channel, with WAIT_STATES programmable wait cycles.
//
// Optional feature macro: DMEM_RESP_ERR_CHECK_EN
//   defined   -> misaligned or out-of-range addresses fault (rsp_err_o=1,
//                stores write nothing, loads return 0).
//   undefined -> rsp_err_o tied 0; the address wraps modulo DEPTH words.
//
// Timing: a request accepted on edge N always spends WAIT_STATES+1 cycles in
// WAIT. The RAM access happens on the edge that leaves WAIT, so rsp_valid_o
// rises after edge N+1+WAIT_STATES. WAIT_STATES=0 still passes through WAIT
// for one cycle, because the registered RAM read needs an edge of its own.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    write_reg;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic                    fault_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [NB-1:0]           be_reg;
  logic                    accept;
  logic                    access;
  logic                    req_fault;
  logic [DATA_WIDTH-1:0]   wmask;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef DMEM_RESP_ERR_CHECK_EN
  // Fault when any byte-offset bit or any bit above the word index is set.
  assign req_fault = (|(req_addr_i << (DATA_WIDTH - OFF))) |
                     (|(req_addr_i >> (OFF + ADDR_WIDTH)));
`else
  // Offset and upper address bits are deliberately ignored: address wraps.
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addr_i};
  assign req_fault   = 1'b0;
`endif

  // Expand byte enables into a bit mask for the read-modify-write store.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{be_reg[gi]}};
    end
  endgenerate

  assign req_ready_o = (state_reg == S_IDLE);
  assign rsp_valid_o = (state_reg == S_RESP);

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    access     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid_i) begin
          accept     = 1'b1;
          cnt_next   = 4'(WAIT_STATES);
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          access     = 1'b1;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, wait counter and the request fields captured on the accept edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      idx_reg   <= '0;
      fault_reg <= 1'b0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= req_write_i;
        idx_reg   <= req_addr_i[OFF +: ADDR_WIDTH];
        fault_reg <= req_fault;
        wdata_reg <= req_wdata_i;
        be_reg    <= req_be_i;
      end
    end
  end

  // RAM store on the RESP-entry edge; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (access && write_reg && !fault_reg)
      mem[idx_reg] <= (mem[idx_reg] & ~wmask) | (wdata_reg & wmask);
  end

  // Response data/error registered on the RESP-entry edge, held until the next access.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (access) begin
      rsp_err_o   <= fault_reg;
      rsp_rdata_o <= (write_reg || fault_reg) ? '0 : mem[idx_reg];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Instance dut uses WAIT_STATES=2; instance dut0 uses WAIT_STATES=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(2)) dut (
    .clk_i(clk), .reset_i(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset_n),
    .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_write_i(z_req_write),
    .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata), .req_be_i(z_req_be),
    .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
    .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err)
  );

  // One full transaction on dut with rsp_ready held high; lat=-1 on timeout.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd,
                        output logic er, output int lat);
    int guard;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_be = be;
    req_valid = 1'b1; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      lat++;
      if (lat > 20) break;
    end
    if (lat > 20) lat = -1;
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
    $display("txn w=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d", w, a, d, be, rd, er, lat);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_rsp got rdata=%h err=%b want 0/0", rd, er); end
    do_req(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_data got %h err=%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h08, 32'h0000AA00, 4'b0010, rd, er, lat);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL byte_enable got %h want deadaaef", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; int guard;
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h08; req_be = 4'h0; req_valid = 1'b1; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1 req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_wait_valid got %b want 1", rsp_valid); end
    // Offer a competing store while the response is stalled; it must not be taken.
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADAAEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got valid=%b rdata=%h ready=%b want 1/deadaaef/0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    do_req(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL stall_no_accept got %h want deadaaef", rd); end
  endtask

  task automatic test_addr_check;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h0A, 32'h11223344, 4'hF, rd, er, lat);
`ifdef DMEM_RESP_ERR_CHECK_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misaligned_err got %b want 1", er); end
    do_req(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADAAEF || er !== 1'b0) begin errors++; $display("FAIL misaligned_nowrite got %h err=%b want deadaaef/0", rd, er); end
    do_req(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL range_err got %h err=%b want 0/1", rd, er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL range_latency got %0d want 3", lat); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL misaligned_err got %b want 0", er); end
    do_req(1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL misaligned_wrap got %h want 11223344", rd); end
    do_req(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL range_wrap got %h err=%b want cafef00d/0", rd, er); end
`endif
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd; logic er; int lat; int guard;
    do_req(1'b1, 32'h10, 32'h5A5A5A5A, 4'hF, rd, er, lat);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    req_valid = 1'b1; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_wait got valid=%b ready=%b want 0/0", rsp_valid, req_ready); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL mid_reset_ram got %h want 5a5a5a5a", rd); end
  endtask

  // WAIT_STATES=0 instance: request held valid; a store followed by streaming loads.
  task automatic test_back_to_back;
    logic exp_ready, exp_valid;
    @(negedge clk);
    checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b want 1", z_req_ready); end
    z_req_write = 1'b1; z_req_addr = 32'h04; z_req_wdata = 32'h12345678; z_req_be = 4'hF;
    z_req_valid = 1'b1; z_rsp_ready = 1'b1;
    @(posedge clk); #1 z_req_write = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_ready = (k % 3 == 0);
      exp_valid = (k % 3 == 2);
      checks++;
      if (z_req_ready !== exp_ready || z_rsp_valid !== exp_valid) begin
        errors++;
        $display("FAIL b2b_handshake k=%0d got ready=%b valid=%b want %b/%b", k, z_req_ready, z_rsp_valid, exp_ready, exp_valid);
      end
      if (k >= 5 && exp_valid) begin
        checks++;
        if (z_rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_data k=%0d got %h want 12345678", k, z_rsp_rdata); end
        $display("txn b2b load k=%0d rdata=%h", k, z_rsp_rdata);
      end
    end
    z_req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0; z_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    test_reset;
    test_store_load;
    test_byte_enable;
    test_backpressure;
    test_addr_check;
    test_reset_mid_op;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
